// File: rtl/seri_cikarici_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package seri_cikarici_pkg;

    // Controller states: waiting, shifting bits, one-cycle result announcement.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HESAPLA = 2'd1,
        BITTI   = 2'd2
    } durum_t;

    localparam int VARSAYILAN_GENISLIK = 4;

    // Bits needed for a counter that can hold values 0..genislik.
    function automatic int sayac_genisligi(input int genislik);
        return $clog2(genislik + 1);
    endfunction

endpackage

// File: rtl/seri_cikarici_tam_cikarici.sv
// 1-bit full subtractor: fark = a - b - odunc_giris, with borrow out.
module tam_cikarici
    import seri_cikarici_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic odunc_giris,
    output logic fark,
    output logic odunc_cikis
);

    logic w_ab_farkli;

    // Difference bit and borrow: borrow when a<b, or when a==b and a borrow is pending.
    always_comb begin
        w_ab_farkli = a ^ b;
        fark        = w_ab_farkli ^ odunc_giris;
        odunc_cikis = (~a & b) | (~w_ab_farkli & odunc_giris);
    end

endmodule

// File: rtl/seri_cikarici.sv
// Bit-serial WIDTH-bit subtractor (A - B - borrow_in), LSB first, one bit per clock.
module seri_cikarici
    import seri_cikarici_pkg::*;
#(
    parameter int WIDTH = VARSAYILAN_GENISLIK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_basla,
    input  logic [WIDTH-1:0] in_giris_1,
    input  logic [WIDTH-1:0] in_giris_2,
    input  logic             in_giris_odunc,
    output logic [WIDTH-1:0] out_cikis,
    output logic             out_cikis_odunc,
    output logic             out_mesgul,
    output logic             out_gecerli
);

    localparam int                  SAYAC_W = sayac_genisligi(WIDTH);
    localparam logic [SAYAC_W-1:0]  SON_BIT = SAYAC_W'(WIDTH - 1);

    durum_t             r_durum;
    durum_t             w_durum_next;
    logic [SAYAC_W-1:0] r_sayac;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_odunc;
    logic [WIDTH-1:0]   r_fark;
    logic [WIDTH-1:0]   r_cikis;
    logic               r_cikis_odunc;
    logic               r_gecerli;

    logic               w_fark_bit;
    logic               w_odunc_bit;
    logic               w_son_bit;
    logic [WIDTH-1:0]   w_fark_kaydir;

    // The current LSBs of the operand shift registers feed the single-bit stage.
    tam_cikarici u_tam_cikarici (
        .a           (r_a[0]),
        .b           (r_b[0]),
        .odunc_giris (r_odunc),
        .fark        (w_fark_bit),
        .odunc_cikis (w_odunc_bit)
    );

    // New difference bit enters at the MSB so that after WIDTH shifts bit 0 is at the LSB.
    always_comb begin
        w_son_bit     = (r_sayac == SON_BIT);
        w_fark_kaydir = {w_fark_bit, r_fark[WIDTH-1:1]};
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_durum <= IDLE;
        end else begin
            r_durum <= w_durum_next;
        end
    end

    // Next-state logic: start only from IDLE, announce for exactly one cycle.
    always_comb begin
        w_durum_next = r_durum;
        case (r_durum)
            IDLE:    if (in_basla) w_durum_next = HESAPLA;
            HESAPLA: if (w_son_bit) w_durum_next = BITTI;
            BITTI:   w_durum_next = IDLE;
            default: w_durum_next = IDLE;
        endcase
    end

    // Operand capture, bit-serial shifting and borrow chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_odunc <= 1'b0;
            r_fark  <= '0;
            r_sayac <= '0;
        end else begin
            case (r_durum)
                IDLE: begin
                    if (in_basla) begin
                        r_a     <= in_giris_1;
                        r_b     <= in_giris_2;
                        r_odunc <= in_giris_odunc;
                        r_fark  <= '0;
                        r_sayac <= '0;
                    end
                end
                HESAPLA: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_odunc <= w_odunc_bit;
                    r_fark  <= w_fark_kaydir;
                    r_sayac <= r_sayac + SAYAC_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Result registers update only on completion, so partial values are never visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cikis       <= '0;
            r_cikis_odunc <= 1'b0;
            r_gecerli     <= 1'b0;
        end else begin
            case (r_durum)
                HESAPLA: begin
                    if (w_son_bit) begin
                        r_cikis       <= w_fark_kaydir;
                        r_cikis_odunc <= w_odunc_bit;
                        r_gecerli     <= 1'b1;
                    end
                end
                BITTI:   r_gecerli <= 1'b0;
                default: ;
            endcase
        end
    end

    // Output drive; busy is a pure decode of the state.
    always_comb begin
        out_cikis       = r_cikis;
        out_cikis_odunc = r_cikis_odunc;
        out_gecerli     = r_gecerli;
        out_mesgul      = (r_durum != IDLE);
    end

endmodule

// File: tb/tb_seri_cikarici.sv
// Self-checking bench for seri_cikarici at WIDTH=4.
module tb_seri_cikarici;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         in_basla;
    logic [W-1:0] in_giris_1;
    logic [W-1:0] in_giris_2;
    logic         in_giris_odunc;
    logic [W-1:0] out_cikis;
    logic         out_cikis_odunc;
    logic         out_mesgul;
    logic         out_gecerli;

    int n_assert = 0;
    int n_fail   = 0;

    logic [W-1:0] prev_d  = '0;
    logic         prev_br = 1'b0;

    seri_cikarici #(.WIDTH(W)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_basla        (in_basla),
        .in_giris_1      (in_giris_1),
        .in_giris_2      (in_giris_2),
        .in_giris_odunc  (in_giris_odunc),
        .out_cikis       (out_cikis),
        .out_cikis_odunc (out_cikis_odunc),
        .out_mesgul      (out_mesgul),
        .out_gecerli     (out_gecerli)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         br;
    } vektor_t;

    vektor_t tablo [8];

    task automatic check(input string ad, input int got, input int exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", ad, got, exp);
        end
    endtask

    // Reference: plain integer subtraction, wrapped to W bits; borrow when negative.
    function automatic logic [W:0] model(input int a, input int b, input int bin);
        int f;
        f = a - b - bin;
        return {(f < 0), W'((f + (1 << W)) % (1 << W))};
    endfunction

    // One operation. mode 0: quiet; 1: restart request with A=B=1 on cycle 2;
    // 2: random input noise and random start requests while busy.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         input int mode, input string ad);
        logic [W:0]   exp_v;
        logic [W-1:0] got_d;
        logic         got_br;
        int           nvalid, nbusy, lat;
        exp_v  = model(int'(a), int'(b), int'(bin));
        got_d  = '0;
        got_br = 1'b0;
        nvalid = 0;
        nbusy  = 0;
        lat    = -1;
        @(negedge clk);
        in_giris_1     = a;
        in_giris_2     = b;
        in_giris_odunc = bin;
        in_basla       = 1'b1;
        @(posedge clk);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (out_mesgul) nbusy++;
            if (out_gecerli) begin
                nvalid++;
                if (lat < 0) lat = j;
                got_d  = out_cikis;
                got_br = out_cikis_odunc;
            end
            if (j < 4) begin
                check({ad, " hold_d"}, int'(out_cikis), int'(prev_d));
            end
            if (j == 0) in_basla = 1'b0;
            if (mode == 1 && j == 1) begin
                in_basla   = 1'b1;
                in_giris_1 = 4'd1;
                in_giris_2 = 4'd1;
            end
            if (mode == 2 && j < 3) begin
                in_basla       = 1'($urandom_range(0, 1));
                in_giris_1     = W'($urandom);
                in_giris_2     = W'($urandom);
                in_giris_odunc = 1'($urandom_range(0, 1));
            end
            if (j >= 2 && mode != 2) in_basla = 1'b0;
            if (j >= 3) in_basla = 1'b0;
        end
        check({ad, " valid_count"}, nvalid, 1);
        check({ad, " latency"}, lat, W);
        check({ad, " busy_cycles"}, nbusy, W + 1);
        check({ad, " diff"}, int'(got_d), int'(exp_v[W-1:0]));
        check({ad, " borrow"}, int'(got_br), int'(exp_v[W]));
        $display("op A=%0d B=%0d bin=%0d -> d=%0d br=%0d (model %0d/%0d)",
                 a, b, bin, got_d, got_br, exp_v[W-1:0], exp_v[W]);
        prev_d  = exp_v[W-1:0];
        prev_br = exp_v[W];
    endtask

    initial begin
        tablo[0] = '{a: 4'd9,  b: 4'd3,  bin: 1'b0, d: 4'd6,  br: 1'b0};
        tablo[1] = '{a: 4'd3,  b: 4'd5,  bin: 1'b0, d: 4'd14, br: 1'b1};
        tablo[2] = '{a: 4'd0,  b: 4'd0,  bin: 1'b1, d: 4'd15, br: 1'b1};
        tablo[3] = '{a: 4'd15, b: 4'd15, bin: 1'b1, d: 4'd15, br: 1'b1};
        tablo[4] = '{a: 4'd8,  b: 4'd8,  bin: 1'b0, d: 4'd0,  br: 1'b0};
        tablo[5] = '{a: 4'd0,  b: 4'd15, bin: 1'b0, d: 4'd1,  br: 1'b1};
        tablo[6] = '{a: 4'd15, b: 4'd0,  bin: 1'b0, d: 4'd15, br: 1'b0};
        tablo[7] = '{a: 4'd10, b: 4'd9,  bin: 1'b1, d: 4'd0,  br: 1'b0};

        reset          = 1'b1;
        in_basla       = 1'b0;
        in_giris_1     = '0;
        in_giris_2     = '0;
        in_giris_odunc = 1'b0;
        #7;
        check("reset cikis", int'(out_cikis), 0);
        check("reset odunc", int'(out_cikis_odunc), 0);
        check("reset mesgul", int'(out_mesgul), 0);
        check("reset gecerli", int'(out_gecerli), 0);
        #3 reset = 1'b0;

        // Table-driven directed vectors with hand-computed expectations.
        for (int i = 0; i < 8; i++) begin
            vektor_t v;
            v = tablo[i];
            do_op(v.a, v.b, v.bin, 0, $sformatf("tablo%0d", i));
            check($sformatf("tablo%0d d_const", i), int'(prev_d), int'(v.d));
            check($sformatf("tablo%0d br_const", i), int'(out_cikis_odunc), int'(v.br));
        end

        // Second start request while busy is ignored; inputs changing after capture are harmless.
        do_op(4'd7, 4'd2, 1'b0, 1, "restart_ignored");
        check("restart_ignored d", int'(out_cikis), 5);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        in_giris_1 = 4'd12; in_giris_2 = 4'd4; in_giris_odunc = 1'b0; in_basla = 1'b1;
        @(posedge clk);
        @(negedge clk); in_basla = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset cikis", int'(out_cikis), 0);
        check("midreset odunc", int'(out_cikis_odunc), 0);
        check("midreset mesgul", int'(out_mesgul), 0);
        check("midreset gecerli", int'(out_gecerli), 0);
        @(negedge clk);
        reset = 1'b0;
        prev_d  = '0;
        prev_br = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check($sformatf("postreset gecerli%0d", j), int'(out_gecerli), 0);
            check($sformatf("postreset mesgul%0d", j), int'(out_mesgul), 0);
        end
        do_op(4'd12, 4'd4, 1'b0, 0, "after_reset");
        check("after_reset d", int'(out_cikis), 8);

        // Start held high: back-to-back operations every W+2 cycles.
        @(negedge clk);
        in_giris_1 = 4'd10; in_giris_2 = 4'd3; in_giris_odunc = 1'b0; in_basla = 1'b1;
        @(posedge clk);
        for (int j = 0; j < 14; j++) begin
            @(negedge clk);
            check($sformatf("held gecerli%0d", j), int'(out_gecerli),
                  int'(j == W || j == 2 * W + 2));
            check($sformatf("held mesgul%0d", j), int'(out_mesgul),
                  int'(j <= W || (j >= W + 2 && j <= 2 * W + 2)));
            if (out_gecerli) begin
                check($sformatf("held d%0d", j), int'(out_cikis), 7);
                check($sformatf("held br%0d", j), int'(out_cikis_odunc), 0);
            end
            if (j == 2 * W + 2) in_basla = 1'b0;
        end
        $display("held-start sequence done");
        prev_d  = 4'd7;
        prev_br = 1'b0;

        // Exhaustive sweep, alternating quiet and noisy operand/start behaviour.
        for (int i = 0; i < 512; i++) begin
            do_op(W'(i >> 5), W'(i >> 1), 1'(i), (i % 2 == 0) ? 0 : 2,
                  $sformatf("sweep%0d", i));
        end

        // Random operations with random disturbances.
        for (int i = 0; i < 100; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2), $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
